vga_fb_write_arbiter: RTL and testbench
=======================================

// Module: vga_fb_write_arbiter
// PURPOSE
//  Owns the single frame-buffer write port (addr_x/addr_y/color/we) feeding the VGA top.
//  Shares that port between an external host pixel-write requester and an internal rectangle-fill engine.
//  Arbitration is round-robin. The fill engine sequences one pixel per granted cycle in raster order.
// PARAMETERS
//  HD         1280  horizontal active pixels; x range 0..HD-1
//  VD         1024  vertical active lines; y range 0..VD-1
//  COORD_BITS 11    width of every x/y coordinate
// PORTS
//  clk_i          in   1           single clock; all logic on posedge
//  arstn_i        in   1           reset, asynchronous, active-low
//  host_req_i     in   1           host has a pixel write pending
//  host_x_i       in   COORD_BITS  host pixel x
//  host_y_i       in   COORD_BITS  host pixel y
//  host_color_i   in   1           host pixel value
//  host_gnt_o     out  1           host request accepted this cycle (combinational)
//  fill_start_i   in   1           1-cycle pulse: launch fill with the fill_* operands
//  fill_x0_i/fill_y0_i in COORD_BITS  rectangle top-left (inclusive)
//  fill_x1_i/fill_y1_i in COORD_BITS  rectangle bottom-right (inclusive)
//  fill_color_i   in   1           fill value
//  fill_abort_i   in   1           terminate an in-progress fill
//  fill_busy_o    out  1           fill engine not IDLE
//  fill_done_o    out  1           1-cycle pulse: fill finished normally
//  addr_x_o       out  COORD_BITS  frame-buffer write x (registered)
//  addr_y_o       out  COORD_BITS  frame-buffer write y (registered)
//  color_o        out  1           frame-buffer write data (registered)
//  we_o           out  1           frame-buffer write enable (registered)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; round-robin pointer favours host first.
//  Host handshake: req/x/y/color held stable until gnt=1; transfer occurs on the cycle req&gnt.
//  Arbitration: requesters are host (host_req_i) and fill (state==FILL). Sole requester always wins.
//  Both requesting: grant goes to the requester not granted last; the pointer updates only on a grant.
//  Write port: the granted pixel appears on addr/color with we_o=1 exactly 1 cycle after grant.
//  we_o=0 on cycles with no grant.
//  Host pixel with x>=HD or y>=VD: still granted (consumed), but no write is issued (we_o stays 0).
//  FSM IDLE: on fill_start_i latch operands, clamping x1 to min(x1,HD-1) and y1 to min(y1,VD-1).
//  Empty rectangle (x0>x1 or y0>y1 after clamp, or x0>=HD, or y0>=VD): go to DONE, issuing no writes.
//  Otherwise: cur=(x0,y0) and go to FILL.
//  FSM FILL: on each fill grant, emit cur. Then if cur_x<x1, cur_x++.
//    Else, if cur_y<y1: cur_x=x0, cur_y++.
//    Else (last pixel): go to DONE.
//  FSM DONE: fill_done_o=1 for this one cycle, then IDLE. busy=1 in FILL and DONE.
//  fill_start_i outside IDLE is ignored; the operands are not re-latched.
//  fill_abort_i in FILL or DONE: next state IDLE, no done pulse.
//    The write already granted that cycle still completes on the port.
//  fill_abort_i and fill_start_i together in IDLE: start wins, abort ignored.
//  Pixel count of a fill = (x1-x0+1)*(y1-y0+1). No coordinate overflows COORD_BITS because of the clamp.
//  Async reset mid-fill: immediate IDLE; we_o drops to 0 asynchronously; no done pulse.
// TESTING
//  1. Reset, host writes (5,7,1) alone -> gnt same cycle; next cycle we_o=1, addr=(5,7), color=1.
//  2. Fill (2,3)-(4,4) color 1, host idle -> 6 writes back-to-back: (2,3)(3,3)(4,3)(2,4)(3,4)(4,4);
//     then done pulse 1 cycle after the last grant.
//  3. Fill (0,0)-(3,0) with host_req_i held high for 4 pixels -> grants alternate host,fill,host,...;
//     all 4 fill pixels and 4 host pixels written; no write is lost or duplicated.
//  4. Fill (1278,1022)-(2000,2000) -> clamped to (1278..1279, 1022..1023): exactly 4 writes, then done.
//     Fill (10,5)-(3,5) -> 0 writes, done pulse 1 cycle after start.
//  5. Host write (1280,0) -> gnt=1 but we_o stays 0.
//     fill_start_i pulsed mid-fill -> ignored; the original rectangle completes unchanged.
//  6. fill_abort_i after 3 pixels of a 10x10 fill -> 3 or 4 writes total, busy=0 next cycle, no done.
//     arstn_i low mid-fill -> we_o=0, busy=0 immediately.

Source files
------------

// File: rtl/vga_fb_write_arbiter.sv
// Round-robin owner of the frame-buffer write port, shared by host pixel writes and a rectangle-fill engine.
// Grant is combinational; the granted pixel reaches addr/color/we one cycle later.
module vga_fb_write_arbiter #(
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int COORD_BITS = 11
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  host_req_i,
  input  logic [COORD_BITS-1:0] host_x_i,
  input  logic [COORD_BITS-1:0] host_y_i,
  input  logic                  host_color_i,
  output logic                  host_gnt_o,
  input  logic                  fill_start_i,
  input  logic [COORD_BITS-1:0] fill_x0_i,
  input  logic [COORD_BITS-1:0] fill_y0_i,
  input  logic [COORD_BITS-1:0] fill_x1_i,
  input  logic [COORD_BITS-1:0] fill_y1_i,
  input  logic                  fill_color_i,
  input  logic                  fill_abort_i,
  output logic                  fill_busy_o,
  output logic                  fill_done_o,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic                  color_o,
  output logic                  we_o
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [COORD_BITS-1:0] X_LIM = COORD_BITS'(HD);
  localparam logic [COORD_BITS-1:0] Y_LIM = COORD_BITS'(VD);
  localparam logic [COORD_BITS-1:0] X_MAX = COORD_BITS'(HD - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX = COORD_BITS'(VD - 1);

  state_t                state;
  logic [COORD_BITS-1:0] x0_q, x1_q, y1_q, cur_x, cur_y;
  logic                  color_q;
  logic                  last_fill_q;

  logic [COORD_BITS-1:0] x1_cl, y1_cl;
  logic                  rect_empty, fill_req, fill_gnt, host_in_range;

  assign x1_cl = (fill_x1_i > X_MAX) ? X_MAX : fill_x1_i;
  assign y1_cl = (fill_y1_i > Y_MAX) ? Y_MAX : fill_y1_i;
  assign rect_empty = (fill_x0_i > x1_cl) || (fill_y0_i > y1_cl) ||
                      (fill_x0_i >= X_LIM) || (fill_y0_i >= Y_LIM);

  // last_fill_q set means the fill engine won most recently, so host is favoured next
  assign fill_req      = (state == FILL);
  assign host_gnt_o    = host_req_i && (!fill_req || last_fill_q);
  assign fill_gnt      = fill_req && (!host_req_i || !last_fill_q);
  assign host_in_range = (host_x_i < X_LIM) && (host_y_i < Y_LIM);

  assign fill_busy_o = (state != IDLE);
  assign fill_done_o = (state == DONE) && !fill_abort_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      we_o        <= 1'b0;
      addr_x_o    <= '0;
      addr_y_o    <= '0;
      color_o     <= 1'b0;
      last_fill_q <= 1'b1;
    end else begin
      if (host_gnt_o) begin
        we_o        <= host_in_range;
        addr_x_o    <= host_x_i;
        addr_y_o    <= host_y_i;
        color_o     <= host_color_i;
        last_fill_q <= 1'b0;
      end else if (fill_gnt) begin
        we_o        <= 1'b1;
        addr_x_o    <= cur_x;
        addr_y_o    <= cur_y;
        color_o     <= color_q;
        last_fill_q <= 1'b1;
      end else begin
        we_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      color_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start_i) begin
            x0_q    <= fill_x0_i;
            x1_q    <= x1_cl;
            y1_q    <= y1_cl;
            cur_x   <= fill_x0_i;
            cur_y   <= fill_y0_i;
            color_q <= fill_color_i;
            state   <= rect_empty ? DONE : FILL;
          end
        end
        FILL: begin
          if (fill_abort_i) begin
            state <= IDLE;
          end else if (fill_gnt) begin
            if (cur_x < x1_q) begin
              cur_x <= cur_x + 1'b1;
            end else if (cur_y < y1_q) begin
              cur_x <= x0_q;
              cur_y <= cur_y + 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Randomized bench for vga_fb_write_arbiter against a queue-based pixel model.
module tb_vga_fb_write_arbiter;

  localparam int HD = 1280;
  localparam int VD = 1024;
  localparam int CB = 11;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          host_req_i, host_color_i, host_gnt_o;
  logic [CB-1:0] host_x_i, host_y_i;
  logic          fill_start_i, fill_color_i, fill_abort_i, fill_busy_o, fill_done_o;
  logic [CB-1:0] fill_x0_i, fill_y0_i, fill_x1_i, fill_y1_i;
  logic [CB-1:0] addr_x_o, addr_y_o;
  logic          color_o, we_o;

  always #5 clk_i = ~clk_i;

  vga_fb_write_arbiter #(.HD(HD), .VD(VD), .COORD_BITS(CB)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .host_req_i(host_req_i), .host_x_i(host_x_i), .host_y_i(host_y_i),
    .host_color_i(host_color_i), .host_gnt_o(host_gnt_o),
    .fill_start_i(fill_start_i), .fill_x0_i(fill_x0_i), .fill_y0_i(fill_y0_i),
    .fill_x1_i(fill_x1_i), .fill_y1_i(fill_y1_i), .fill_color_i(fill_color_i),
    .fill_abort_i(fill_abort_i), .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .color_o(color_o), .we_o(we_o)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // stimulus state, held between cycles
  bit h_req, h_c, f_start, f_abort, f_c;
  int h_x, h_y, f_x0, f_y0, f_x1, f_y1;

  // reference model: remaining fill pixels as queues in raster order
  bit m_filling, m_done, m_last_fill;
  int qx[$], qy[$];
  bit m_color;
  bit e_we, e_c;
  int e_x, e_y;
  int host_writes, fill_writes;

  task automatic model_reset();
    m_filling = 0; m_done = 0; m_last_fill = 1;
    qx.delete(); qy.delete();
    e_we = 0; e_x = 0; e_y = 0; e_c = 0;
  endtask

  task automatic model_start();
    int xe, ye;
    xe = (f_x1 > HD - 1) ? HD - 1 : f_x1;
    ye = (f_y1 > VD - 1) ? VD - 1 : f_y1;
    m_color = f_c;
    for (int y = f_y0; y <= ye; y++)
      for (int x = f_x0; x <= xe; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    if (qx.size() == 0) m_done = 1;
    else m_filling = 1;
  endtask

  // one cycle; entered and left at negedge
  task automatic step();
    bit exp_hg, exp_fg;
    check("we", we_o, e_we);
    if (e_we) begin
      check("addr_x", addr_x_o, e_x);
      check("addr_y", addr_y_o, e_y);
      check("color", color_o, e_c);
    end
    check("busy", fill_busy_o, m_filling || m_done);
    host_req_i = h_req; host_x_i = CB'(h_x); host_y_i = CB'(h_y); host_color_i = h_c;
    fill_start_i = f_start; fill_abort_i = f_abort; fill_color_i = f_c;
    fill_x0_i = CB'(f_x0); fill_y0_i = CB'(f_y0); fill_x1_i = CB'(f_x1); fill_y1_i = CB'(f_y1);
    #1;
    exp_hg = h_req && (!m_filling || m_last_fill);
    exp_fg = m_filling && (!h_req || !m_last_fill);
    check("host_gnt", host_gnt_o, exp_hg);
    check("done", fill_done_o, m_done && !f_abort);
    if (exp_hg) begin
      m_last_fill = 0;
      e_we = (h_x < HD) && (h_y < VD);
      e_x = h_x; e_y = h_y; e_c = h_c;
      if (e_we) host_writes++;
    end else if (exp_fg) begin
      m_last_fill = 1;
      e_we = 1; e_x = qx.pop_front(); e_y = qy.pop_front(); e_c = m_color;
      fill_writes++;
    end else begin
      e_we = 0;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_filling) begin
      if (f_abort) begin
        m_filling = 0; qx.delete(); qy.delete();
      end else if (qx.size() == 0) begin
        m_filling = 0; m_done = 1;
      end
    end else if (f_start) begin
      model_start();
    end
    if (exp_hg) h_req = 0;
    f_start = 0; f_abort = 0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_fill(input int x0, input int y0, input int x1, input int y1, input bit c);
    f_start = 1; f_x0 = x0; f_y0 = y0; f_x1 = x1; f_y1 = y1; f_c = c;
  endtask

  function automatic int rand_span(input int base, input int lim, input int big);
    int r;
    r = $urandom_range(7);
    if (r == 0 && base > 0) return base - 1;
    if (r == 1) return big;
    return base + $urandom_range(3);
  endfunction

  task automatic rand_rect();
    if ($urandom_range(1) == 0) f_x0 = $urandom_range(6);
    else f_x0 = HD - 4 + $urandom_range(6);
    if ($urandom_range(1) == 0) f_y0 = $urandom_range(6);
    else f_y0 = VD - 4 + $urandom_range(6);
    f_x1 = rand_span(f_x0, HD, 2000);
    f_y1 = rand_span(f_y0, VD, 2000);
    if (f_x0 < HD - 8 && f_x1 == 2000) f_x1 = f_x0 + 2;
    if (f_y0 < VD - 8 && f_y1 == 2000) f_y1 = f_y0 + 2;
    f_c = 1'($urandom_range(1));
    f_start = 1;
  endtask

  initial begin
    h_req = 0; h_c = 0; h_x = 0; h_y = 0;
    f_start = 0; f_abort = 0; f_c = 0; f_x0 = 0; f_y0 = 0; f_x1 = 0; f_y1 = 0;
    host_req_i = 0; host_x_i = 0; host_y_i = 0; host_color_i = 0;
    fill_start_i = 0; fill_abort_i = 0; fill_color_i = 0;
    fill_x0_i = 0; fill_y0_i = 0; fill_x1_i = 0; fill_y1_i = 0;
    host_writes = 0; fill_writes = 0;
    model_reset();
    arstn_i = 0;
    repeat (2) @(negedge clk_i);
    check("rst_we", we_o, 0);
    check("rst_busy", fill_busy_o, 0);
    check("rst_done", fill_done_o, 0);
    check("rst_addr_x", addr_x_o, 0);
    check("rst_addr_y", addr_y_o, 0);
    check("rst_color", color_o, 0);
    arstn_i = 1;

    h_req = 1; h_x = 5; h_y = 7; h_c = 1;
    step(); step();
    set_fill(2, 3, 4, 4, 1);
    repeat (9) step();
    set_fill(0, 0, 3, 0, 0); h_req = 1; h_x = 100; h_y = 200; h_c = 1;
    step();
    for (int i = 0; i < 12; i++) begin
      if (!h_req && i < 6) begin h_req = 1; h_x = 100 + i; h_y = 200; h_c = 1'(i); end
      step();
    end
    set_fill(1278, 1022, 2000, 2000, 1);
    repeat (8) step();
    set_fill(10, 5, 3, 5, 1);
    repeat (3) step();
    h_req = 1; h_x = 1280; h_y = 0; h_c = 1;
    step(); step();
    set_fill(20, 20, 23, 21, 1);
    repeat (3) step();
    set_fill(0, 0, 50, 50, 0);
    repeat (8) step();

    for (int n = 0; n < 3000; n++) begin
      if (!h_req && $urandom_range(2) == 0) begin
        h_req = 1;
        h_x = $urandom_range(HD - 1); h_y = $urandom_range(VD - 1);
        if ($urandom_range(7) == 0) h_x = HD + $urandom_range(10);
        if ($urandom_range(7) == 0) h_y = VD + $urandom_range(6);
        h_c = 1'($urandom_range(1));
      end
      if ($urandom_range(5) == 0) rand_rect();
      if ((m_filling || m_done) && $urandom_range(39) == 0) f_abort = 1;
      if (!(m_filling || m_done) && f_start && $urandom_range(9) == 0) f_abort = 1;
      step();
    end

    h_req = 0;
    repeat (30) step();
    set_fill(0, 0, 9, 9, 1);
    repeat (3) step();
    f_abort = 1;
    step();
    check("abort_busy", fill_busy_o, 0);
    repeat (2) step();
    set_fill(0, 0, 9, 9, 1);
    repeat (5) step();
    check("pre_rst_we", we_o, 1);
    #2 arstn_i = 0;
    #1;
    check("arst_we", we_o, 0);
    check("arst_busy", fill_busy_o, 0);
    check("arst_done", fill_done_o, 0);
    model_reset();
    @(negedge clk_i);
    arstn_i = 1;
    repeat (3) step();
    if (host_writes == 0) check("host_writes_seen", host_writes, 1);
    if (fill_writes == 0) check("fill_writes_seen", fill_writes, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
